// File: rtl/adder_slice_sequencer.sv
// Wide adder built by sequencing one external 7-bit slice over NUM_SLICES chunks, LSB chunk first.
// Optional signed-overflow output is built only when SEQ_OVERFLOW_EN is defined.
module adder_slice_sequencer #(
  parameter int NUM_SLICES = 4,
  localparam int W = 7 * NUM_SLICES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic [6:0]   slice_a,
  output logic [6:0]   slice_b,
  output logic         slice_cin,
  output logic         slice_en,
  input  logic [6:0]   slice_sum,
  input  logic         slice_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
`ifdef SEQ_OVERFLOW_EN
  ,
  output logic         out_ovf
`endif
);

  localparam int IW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg;
  logic [IW-1:0] idx_reg;
  logic          carry_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [6:0]    sum_chunk_reg [NUM_SLICES];
  logic [6:0]    a_chunk [NUM_SLICES];
  logic [6:0]    b_chunk [NUM_SLICES];
  logic          run;
  logic          done;

  assign run  = (state_reg == RUN);
  assign done = (state_reg == DONE);

  // Chunk views of the operands and assembly of the result, one 7-bit lane per slice step.
  for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_chunk
    assign a_chunk[gi]          = a_reg[7*gi +: 7];
    assign b_chunk[gi]          = b_reg[7*gi +: 7];
    assign out_sum[7*gi +: 7]   = done ? sum_chunk_reg[gi] : 7'd0;
  end

  assign in_ready  = (state_reg == IDLE);
  assign slice_en  = run;
  assign slice_a   = run ? a_chunk[idx_reg] : 7'd0;
  assign slice_b   = run ? b_chunk[idx_reg] : 7'd0;
  assign slice_cin = run ? carry_reg : 1'b0;
  assign out_valid = done;
  assign out_cout  = done ? carry_reg : 1'b0;

`ifdef SEQ_OVERFLOW_EN
  logic ovf_reg;
  assign out_ovf = ovf_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      for (int i = 0; i < NUM_SLICES; i++) sum_chunk_reg[i] <= 7'd0;
`ifdef SEQ_OVERFLOW_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry_reg <= in_cin;
            idx_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          sum_chunk_reg[idx_reg] <= slice_sum;
          carry_reg              <= slice_cout;
          if (idx_reg == LAST_IDX) begin
            state_reg <= DONE;
`ifdef SEQ_OVERFLOW_EN
            // Carry into the top bit is recovered from the top slice's sum and operand MSBs.
            ovf_reg   <= slice_cout ^ (slice_sum[6] ^ slice_a[6] ^ slice_b[6]);
`endif
          end else begin
            idx_reg <= idx_reg + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
`ifdef SEQ_OVERFLOW_EN
            ovf_reg   <= 1'b0;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_slice_sequencer.sv
// Bench for adder_slice_sequencer: behavioural slice model plus a whole-width arithmetic reference.
module tb_adder_slice_sequencer;

  localparam int NS = 4;
  localparam int W  = 7 * NS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic [6:0]   slice_a;
  logic [6:0]   slice_b;
  logic         slice_cin;
  logic         slice_en;
  logic [6:0]   slice_sum;
  logic         slice_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // External 7-bit slice: plain 8-bit addition.
  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {7'd0, slice_cin};

  adder_slice_sequencer #(.NUM_SLICES(NS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin), .slice_en(slice_en),
    .slice_sum(slice_sum), .slice_cout(slice_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
`ifdef SEQ_OVERFLOW_EN
    , .out_ovf(out_ovf)
`endif
  );

`ifndef SEQ_OVERFLOW_EN
  assign out_ovf = 1'b0;
`endif

  // Reference: full-width unsigned sum and signed overflow of a + b + cin.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] s;
    s = ref_add(a, b, c);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // Drives one request and collects what the DUT shows; comparisons are made by the callers.
  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int hold, input bit early_ready,
                        output logic [W-1:0] sum, output logic cout, output logic ovf,
                        output int lat, output int en_cnt, output logic [NS-1:0] cins);
    int k;
    cins = '0; en_cnt = 0; lat = 0;
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = c;
    out_ready = early_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin
      if (slice_en) begin
        if (en_cnt < NS) cins[en_cnt] = slice_cin;
        en_cnt++;
      end
      @(posedge clk); #1; k++;
    end
    lat  = k;
    sum  = out_sum; cout = out_cout; ovf = out_ovf;
    if (!early_ready) begin
      for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else passed++;
    total++; if ({out_valid, slice_en, out_cout, out_ovf} !== 4'b0)
      $display("FAIL reset_flags got=%b want=0000", {out_valid, slice_en, out_cout, out_ovf}); else passed++;
    total++; if ({out_sum, slice_a, slice_b, slice_cin} !== '0)
      $display("FAIL reset_data got=%h/%h/%h/%b want=0", out_sum, slice_a, slice_b, slice_cin); else passed++;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [3] = '{28'h0000005, 28'hFFFFFFF, 28'h0000000};
    logic [W-1:0] vb [3] = '{28'h0000003, 28'h0000001, 28'hFFFFFFF};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] exp_sum [3] = '{28'h0000008, 28'h0000000, 28'h0000000};
    logic         exp_cout [3] = '{1'b0, 1'b1, 1'b1};
    logic [W-1:0] s; logic co, ov; int lat, en; logic [NS-1:0] cins;
    for (int t = 0; t < 3; t++) begin
      do_txn(va[t], vb[t], vc[t], 0, 1'b0, s, co, ov, lat, en, cins);
      $display("directed %0d: a=%h b=%h cin=%b -> sum=%h cout=%b lat=%0d", t, va[t], vb[t], vc[t], s, co, lat);
      total++; if (s !== exp_sum[t]) $display("FAIL dir_sum%0d got=%h want=%h", t, s, exp_sum[t]); else passed++;
      total++; if (co !== exp_cout[t]) $display("FAIL dir_cout%0d got=%b want=%b", t, co, exp_cout[t]); else passed++;
      total++; if (lat !== NS) $display("FAIL dir_latency%0d got=%0d want=%0d", t, lat, NS); else passed++;
      total++; if (en !== NS) $display("FAIL dir_en_cycles%0d got=%0d want=%0d", t, en, NS); else passed++;
      if (t == 1) begin
        total++; if (cins !== 4'b1110) $display("FAIL ripple_cins got=%b want=1110", cins); else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, held; logic hc; int k;
    logic [W:0] r;
    a = W'($urandom); b = W'($urandom);
    r = ref_add(a, b, 1'b0);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    in_a = 28'h1; in_b = 28'h1;
    k = 0;
    while (!out_valid && k < 50) begin @(posedge clk); #1; k++; end
    total++; if (k !== NS) $display("FAIL bp_latency got=%0d want=%0d", k, NS); else passed++;
    held = out_sum; hc = out_cout;
    $display("backpressure: a=%h b=%h -> sum=%h cout=%b", a, b, held, hc);
    total++; if ({hc, held} !== r) $display("FAIL bp_result got=%h want=%h", {hc, held}, r); else passed++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== r[W-1:0] || out_cout !== r[W])
        $display("FAIL bp_hold%0d got=v%b r%b %h/%b want=v1 r0 %h/%b", i, out_valid, in_ready, out_sum, out_cout, r[W-1:0], r[W]);
      else passed++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release got=r%b v%b want=r1 v0", in_ready, out_valid); else passed++;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] a, b, s; logic co, ov; int lat, en; logic [NS-1:0] cins;
    logic [W:0] r;
    in_valid = 1'b1; in_a = 28'hABCDEF1; in_b = 28'h1234567; in_cin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (in_ready !== 1'b1 || slice_en !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL midrst_ctrl got=r%b e%b v%b want=r1 e0 v0", in_ready, slice_en, out_valid); else passed++;
    total++; if ({out_sum, out_cout, out_ovf, slice_a, slice_b, slice_cin} !== '0)
      $display("FAIL midrst_data got=%h/%b/%b/%h/%h/%b want=0", out_sum, out_cout, out_ovf, slice_a, slice_b, slice_cin); else passed++;
    a = W'($urandom); b = W'($urandom);
    r = ref_add(a, b, 1'b0);
    do_txn(a, b, 1'b0, 1, 1'b0, s, co, ov, lat, en, cins);
    $display("after reset: a=%h b=%h -> sum=%h cout=%b", a, b, s, co);
    total++; if ({co, s} !== r || lat !== NS) $display("FAIL midrst_fresh got=%h lat=%0d want=%h lat=%0d", {co, s}, lat, r, NS); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, s; logic c, co, ov; int lat, en; logic [NS-1:0] cins;
    logic [W:0] r; logic eo; bit early;
    for (int t = 0; t < 40; t++) begin
      case (t % 4)
        0: begin a = W'($urandom); b = W'($urandom); end
        1: begin a = {W{1'b1}}; b = W'($urandom_range(0, 3)); end
        2: begin a = {1'b0, {(W-1){1'b1}}}; b = W'($urandom_range(1, 200)); end
        default: begin a = {1'b1, W'($urandom) >> 1}; b = {1'b1, W'($urandom) >> 1}; end
      endcase
      c = 1'($urandom);
      early = (t % 3 == 0);
      r = ref_add(a, b, c); eo = ref_ovf(a, b, c);
      do_txn(a, b, c, int'($urandom_range(0, 3)), early, s, co, ov, lat, en, cins);
      $display("txn %0d: a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b lat=%0d", t, a, b, c, s, co, ov, lat);
      total++; if ({co, s} !== r) $display("FAIL b2b_result%0d got=%h want=%h", t, {co, s}, r); else passed++;
      total++; if (lat !== NS || en !== NS) $display("FAIL b2b_timing%0d got=lat%0d en%0d want=%0d", t, lat, en, NS); else passed++;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL b2b_after%0d got=v%b r%b want=v0 r1", t, out_valid, in_ready); else passed++;
`ifdef SEQ_OVERFLOW_EN
      total++; if (ov !== eo) $display("FAIL b2b_ovf%0d got=%b want=%b", t, ov, eo); else passed++;
`else
      total++; if (ov !== 1'b0) $display("FAIL b2b_ovf%0d got=%b want=0", t, ov); else passed++;
`endif
    end
  endtask

`ifdef SEQ_OVERFLOW_EN
  task automatic test_overflow();
    logic [W-1:0] s; logic co, ov; int lat, en; logic [NS-1:0] cins;
    do_txn(28'h7FFFFFF, 28'h0000001, 1'b0, 0, 1'b0, s, co, ov, lat, en, cins);
    $display("ovf case 1: sum=%h cout=%b ovf=%b", s, co, ov);
    total++; if ({s, co, ov} !== {28'h8000000, 1'b0, 1'b1}) $display("FAIL ovf1 got=%h/%b/%b want=8000000/0/1", s, co, ov); else passed++;
    total++; if (out_ovf !== 1'b0) $display("FAIL ovf1_clear got=%b want=0", out_ovf); else passed++;
    do_txn(28'h8000000, 28'h8000000, 1'b0, 0, 1'b0, s, co, ov, lat, en, cins);
    $display("ovf case 2: sum=%h cout=%b ovf=%b", s, co, ov);
    total++; if ({s, co, ov} !== {28'h0000000, 1'b1, 1'b1}) $display("FAIL ovf2 got=%h/%b/%b want=0000000/1/1", s, co, ov); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
`ifdef SEQ_OVERFLOW_EN
    test_overflow();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_slice_sequencer.md
# adder_slice_sequencer

Multi-cycle controller that performs a wide (NUM_SLICES × 7-bit) addition by time-multiplexing one external 7-bit conditional-sum adder slice. It sits between a valid/ready operand source and a valid/ready result sink. It captures full-width operands, feeds the slice one 7-bit chunk per cycle (LSB chunk first), carries the slice carry-out into the next chunk, and assembles the full-width sum and final carry.

## Interface
- NUM_SLICES, 4, number of 7-bit chunks; operand width W = 7*NUM_SLICES (min 1)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand source has a request
- in_ready  out  1  controller can accept a request
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_cin  in  1  carry into bit 0
- slice_a  out  7  chunk of A presented to the adder slice
- slice_b  out  7  chunk of B presented to the adder slice
- slice_cin  out  1  carry presented to the adder slice
- slice_en  out  1  slice inputs valid this cycle
- slice_sum  in  7  slice sum, combinational, same cycle
- slice_cout  in  1  slice carry-out, combinational, same cycle
- out_valid  out  1  result available
- out_ready  in  1  result sink accepts
- out_sum  out  W  assembled sum
- out_cout  out  1  carry out of bit W-1
- out_ovf  out  1  signed overflow (only with SEQ_OVERFLOW_EN)

## Operation
- States: IDLE, RUN, DONE. Chunk index idx ranges 0..NUM_SLICES-1.
- IDLE:
  - in_ready=1.
  - On in_valid=1, register in_a, in_b and in_cin, set idx=0, carry_reg=in_cin, and go to RUN.
- RUN:
  - slice_en=1; slice_a = a_reg[7*idx +: 7]; slice_b = b_reg[7*idx +: 7]; slice_cin = carry_reg.
  - Each edge: sum_reg[7*idx +: 7] <= slice_sum; carry_reg <= slice_cout.
  - If idx == NUM_SLICES-1, go to DONE. Otherwise idx <= idx+1.
- DONE:
  - out_valid=1; out_sum = sum_reg; out_cout = carry_reg.
  - Outputs are held stable until out_ready=1, then go to IDLE.
- in_ready is 0 in RUN and DONE. Requests are not pipelined; in_valid is ignored outside IDLE.
- Outside RUN: slice_en=0 and slice_a/slice_b/slice_cin are driven 0.
- Arithmetic is unsigned modulo 2^W. out_cout is the true carry out of bit W-1.
- Reset (any state, including mid-RUN): state=IDLE, idx=0, carry_reg=0, sum_reg=0, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, slice_en=0, slice outputs 0. Any in-flight operation is discarded.

## Timing
- Acceptance edge: the edge with state=IDLE and in_valid=1.
- slice_en is high for exactly NUM_SLICES consecutive cycles, starting the cycle after acceptance.
- out_valid rises exactly NUM_SLICES edges after the acceptance edge.
- Handshake edge: the edge with out_valid & out_ready. The state becomes IDLE on that edge.
  - in_ready=1 in the following cycle.
  - A new request can be accepted on the next edge. Minimum request spacing is NUM_SLICES+2 cycles.
- If out_ready is high when DONE is entered, out_valid stays high for one cycle.
- Slice interface is combinational: slice_sum/slice_cout must settle within the same cycle as slice_a/slice_b/slice_cin.

## Configuration
- SEQ_OVERFLOW_EN defined:
  - In the last RUN cycle, register out_ovf <= slice_cout ^ (slice_sum[6] ^ slice_a[6] ^ slice_b[6]), i.e. carry into MSB XOR carry out.
  - out_ovf is valid with out_valid and cleared to 0 on reset and on leaving DONE.
- SEQ_OVERFLOW_EN undefined: out_ovf port is absent and no overflow logic is built.

## Test plan
Bench uses a behavioural 7-bit slice model; NUM_SLICES=4 (W=28).
- Basic add: in_a=28'h0000005, in_b=28'h0000003, in_cin=0 -> out_sum=28'h0000008, out_cout=0; out_valid exactly 4 edges after acceptance.
- Full ripple: in_a=28'hFFFFFFF, in_b=28'h0000001, cin=0 -> out_sum=0, out_cout=1; slice_cin observed as 0,1,1,1 across the 4 RUN cycles.
- Carry-in: in_a=28'h0000000, in_b=28'hFFFFFFF, cin=1 -> out_sum=0, out_cout=1.
- Backpressure: out_ready=0 for 5 cycles in DONE:
  - out_sum/out_cout held stable; in_ready=0 throughout; in_valid with in_a=28'h1 ignored.
  - After the handshake edge, in_ready=1.
- Reset mid-RUN: assert rst on the 2nd RUN cycle -> next cycle state IDLE, in_ready=1, slice_en=0, all outputs 0; a fresh request then completes correctly.
- (SEQ_OVERFLOW_EN) in_a=28'h7FFFFFF, in_b=28'h0000001 -> out_sum=28'h8000000, out_ovf=1, out_cout=0; in_a=28'h8000000, in_b=28'h8000000 -> out_sum=0, out_ovf=1, out_cout=1.
